// File: rtl/alu_multicycle_pkg.sv
// rtl/alu_multicycle_pkg.sv - opcodes, FSM states and opcode classifiers for the multicycle ALU
package alu_multicycle_pkg;

    typedef enum logic [4:0] {
        OP_ADD    = 5'd0,
        OP_SUB    = 5'd1,
        OP_AND    = 5'd2,
        OP_OR     = 5'd3,
        OP_XOR    = 5'd4,
        OP_SLL    = 5'd5,
        OP_SRL    = 5'd6,
        OP_SRA    = 5'd7,
        OP_SLT    = 5'd8,
        OP_SLTU   = 5'd9,
        OP_BEQ    = 5'd10,
        OP_BNE    = 5'd11,
        OP_BLT    = 5'd12,
        OP_BGE    = 5'd13,
        OP_BLTU   = 5'd14,
        OP_BGEU   = 5'd15,
        OP_MUL    = 5'd16,
        OP_MULH   = 5'd17,
        OP_MULHSU = 5'd18,
        OP_MULHU  = 5'd19,
        OP_DIV    = 5'd20,
        OP_DIVU   = 5'd21,
        OP_REM    = 5'd22,
        OP_REMU   = 5'd23
    } alu_op_e;

    localparam int NUM_OPS = 24;

    typedef enum logic [1:0] {IDLE, ITER, DONE} alu_state_t;

    function automatic logic is_mul(input logic [4:0] op);
        return op inside {OP_MUL, OP_MULH, OP_MULHSU, OP_MULHU};
    endfunction

    function automatic logic is_div(input logic [4:0] op);
        return op inside {OP_DIV, OP_DIVU, OP_REM, OP_REMU};
    endfunction

    function automatic logic op_a_signed(input logic [4:0] op);
        return op inside {OP_MULH, OP_MULHSU, OP_DIV, OP_REM};
    endfunction

    function automatic logic op_b_signed(input logic [4:0] op);
        return op inside {OP_MULH, OP_DIV, OP_REM};
    endfunction

endpackage

// File: rtl/alu_multicycle_if.sv
// rtl/alu_multicycle_if.sv - EX-stage handshake bundle between pipeline and ALU
interface alu_multicycle_if #(
    parameter int XLEN = 32,
    parameter int OP_W = 5
);
    logic            flush;
    logic            inValid;
    logic            inReady;
    logic [XLEN-1:0] in1;
    logic [XLEN-1:0] in2;
    logic [OP_W-1:0] aluOperation;
    logic            outValid;
    logic            outReady;
    logic [XLEN-1:0] aluOutput;
    logic            branch;
    logic            busy;

    modport master (
        output flush, inValid, in1, in2, aluOperation, outReady,
        input  inReady, outValid, aluOutput, branch, busy
    );

    modport slave (
        input  flush, inValid, in1, in2, aluOperation, outReady,
        output inReady, outValid, aluOutput, branch, busy
    );
endinterface

// File: rtl/alu_multicycle_iter_muldiv.sv
// rtl/alu_multicycle_iter_muldiv.sv - shared XLEN-step shift-add multiply / restoring divide datapath
module iter_muldiv
    import alu_multicycle_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rstN,
    input  logic            start,
    input  logic            abort,
    input  logic [4:0]      op,
    input  logic [XLEN-1:0] opa,
    input  logic [XLEN-1:0] opb,
    output logic            done,
    output logic [XLEN-1:0] result
);
    localparam int CW = $clog2(XLEN + 1);

    logic [2*XLEN-1:0] acc_q, acc_d, step_acc, prod;
    logic [XLEN-1:0]   opnd_q, opnd_d, mag_a, mag_b, hi, lo, quo, rem;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic              running_q, running_d, div_q, div_d, sel_hi_q, sel_hi_d;
    logic              qneg_q, qneg_d, rneg_q, rneg_d;
    logic              a_neg, b_neg;
    logic [XLEN:0]     mul_sum, div_diff;

    assign a_neg = op_a_signed(op) & opa[XLEN-1];
    assign b_neg = op_b_signed(op) & opb[XLEN-1];
    assign mag_a = a_neg ? -opa : opa;
    assign mag_b = b_neg ? -opb : opb;
    assign hi    = acc_q[2*XLEN-1:XLEN];
    assign lo    = acc_q[XLEN-1:0];
    assign done  = running_q && (cnt_q == CW'(1));

    // Multiply: multiplier sits in lo, partial product grows in hi. Divide: remainder in hi, quotient shifts into lo.
    always_comb begin
        mul_sum  = {1'b0, hi} + (lo[0] ? {1'b0, opnd_q} : '0);
        div_diff = {hi, lo[XLEN-1]} - {1'b0, opnd_q};
        if (div_q) begin
            step_acc = div_diff[XLEN] ? {hi[XLEN-2:0], lo, 1'b0}
                                      : {div_diff[XLEN-1:0], lo[XLEN-2:0], 1'b1};
        end else begin
            step_acc = {mul_sum, lo[XLEN-1:1]};
        end
    end

    // Result is taken from the final step combinationally so it lands in the top's register on the last ITER edge.
    always_comb begin
        prod = qneg_q ? -step_acc : step_acc;
        quo  = qneg_q ? -step_acc[XLEN-1:0] : step_acc[XLEN-1:0];
        rem  = rneg_q ? -step_acc[2*XLEN-1:XLEN] : step_acc[2*XLEN-1:XLEN];
        if (div_q) result = sel_hi_q ? rem : quo;
        else       result = sel_hi_q ? prod[2*XLEN-1:XLEN] : prod[XLEN-1:0];
    end

    always_comb begin
        acc_d     = acc_q;
        opnd_d    = opnd_q;
        cnt_d     = cnt_q;
        running_d = running_q;
        div_d     = div_q;
        sel_hi_d  = sel_hi_q;
        qneg_d    = qneg_q;
        rneg_d    = rneg_q;
        if (start) begin
            acc_d     = {{XLEN{1'b0}}, is_div(op) ? mag_a : mag_b};
            opnd_d    = is_div(op) ? mag_b : mag_a;
            cnt_d     = CW'(XLEN);
            running_d = 1'b1;
            div_d     = is_div(op);
            sel_hi_d  = op inside {OP_MULH, OP_MULHSU, OP_MULHU, OP_REM, OP_REMU};
            qneg_d    = a_neg ^ b_neg;
            rneg_d    = a_neg;
        end else if (running_q) begin
            acc_d     = step_acc;
            cnt_d     = cnt_q - CW'(1);
            running_d = !done;
        end
        if (abort) running_d = 1'b0;
    end

    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            acc_q     <= '0;
            opnd_q    <= '0;
            cnt_q     <= '0;
            running_q <= 1'b0;
            div_q     <= 1'b0;
            sel_hi_q  <= 1'b0;
            qneg_q    <= 1'b0;
            rneg_q    <= 1'b0;
        end else begin
            acc_q     <= acc_d;
            opnd_q    <= opnd_d;
            cnt_q     <= cnt_d;
            running_q <= running_d;
            div_q     <= div_d;
            sel_hi_q  <= sel_hi_d;
            qneg_q    <= qneg_d;
            rneg_q    <= rneg_d;
        end
    end
endmodule

// File: rtl/alu_multicycle.sv
// rtl/alu_multicycle.sv - EX-stage ALU: single-cycle ops, handshake FSM, iterative mul/div dispatch
module alu_multicycle
    import alu_multicycle_pkg::*;
#(
    parameter int XLEN     = 32,
    parameter int FAST_MUL = 1,
    parameter int OP_W     = 5
) (
    input  logic             clk,
    input  logic             rstN,
    alu_multicycle_if.slave  bus
);
    localparam int SH_W = $clog2(XLEN);

    alu_state_t              state_q, state_d;
    logic [XLEN-1:0]         result_q, result_d, sc_result, iter_result, a, b;
    logic                    branch_q, branch_d, sc_branch;
    logic                    accept, goes_iter, iter_done, div_zero, div_ovf, op_known;
    logic [31:0]             op_ext;
    logic [4:0]              op5;
    logic signed [2*XLEN-1:0] fa, fb, fprod;

    assign a        = bus.in1;
    assign b        = bus.in2;
    assign op_ext   = 32'(bus.aluOperation);
    assign op5      = op_ext[4:0];
    assign op_known = op_ext < 32'(NUM_OPS);
    assign div_zero = (b == '0);
    assign div_ovf  = op_a_signed(op5) && (a == {1'b1, {(XLEN-1){1'b0}}}) && (&b);
    assign goes_iter = op_known && ((is_mul(op5) && FAST_MUL == 0) ||
                                    (is_div(op5) && !div_zero && !div_ovf));
    assign accept   = bus.inValid && bus.inReady && !bus.flush;

    assign fa    = {{XLEN{op_a_signed(op5) & a[XLEN-1]}}, a};
    assign fb    = {{XLEN{op_b_signed(op5) & b[XLEN-1]}}, b};
    assign fprod = fa * fb;

    always_comb begin
        sc_result = '0;
        sc_branch = 1'b0;
        if (op_known) begin
            case (op5)
                OP_ADD:  sc_result = a + b;
                OP_SUB:  sc_result = a - b;
                OP_AND:  sc_result = a & b;
                OP_OR:   sc_result = a | b;
                OP_XOR:  sc_result = a ^ b;
                OP_SLL:  sc_result = a << b[SH_W-1:0];
                OP_SRL:  sc_result = a >> b[SH_W-1:0];
                OP_SRA:  sc_result = $signed(a) >>> b[SH_W-1:0];
                OP_SLT:  sc_result = {{(XLEN-1){1'b0}}, $signed(a) < $signed(b)};
                OP_SLTU: sc_result = {{(XLEN-1){1'b0}}, a < b};
                OP_BEQ:  sc_branch = (a == b);
                OP_BNE:  sc_branch = (a != b);
                OP_BLT:  sc_branch = ($signed(a) < $signed(b));
                OP_BGE:  sc_branch = ($signed(a) >= $signed(b));
                OP_BLTU: sc_branch = (a < b);
                OP_BGEU: sc_branch = (a >= b);
                OP_MUL:  sc_result = fprod[XLEN-1:0];
                OP_MULH, OP_MULHSU, OP_MULHU: sc_result = fprod[2*XLEN-1:XLEN];
                // Divide corner cases resolve at accept; the normal case goes to the iterator.
                OP_DIV, OP_DIVU: begin
                    if (div_zero)     sc_result = '1;
                    else if (div_ovf) sc_result = a;
                end
                OP_REM, OP_REMU: begin
                    if (div_zero) sc_result = a;
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        state_d = state_q;
        if (bus.flush) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE: if (accept) state_d = goes_iter ? ITER : DONE;
                ITER: if (iter_done) state_d = DONE;
                DONE: begin
                    if (accept)            state_d = goes_iter ? ITER : DONE;
                    else if (bus.outReady) state_d = IDLE;
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_comb begin
        result_d = result_q;
        branch_d = branch_q;
        if (accept) begin
            branch_d = sc_branch;
            if (!goes_iter) result_d = sc_result;
        end else if (state_q == ITER && iter_done && !bus.flush) begin
            result_d = iter_result;
        end
        bus.inReady   = (state_q == IDLE) || (state_q == DONE && bus.outReady);
        bus.outValid  = (state_q == DONE);
        bus.busy      = (state_q == ITER);
        bus.aluOutput = result_q;
        bus.branch    = branch_q;
    end

    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            state_q  <= IDLE;
            result_q <= '0;
            branch_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            result_q <= result_d;
            branch_q <= branch_d;
        end
    end

    iter_muldiv #(.XLEN(XLEN)) u_iter (
        .clk    (clk),
        .rstN   (rstN),
        .start  (accept && goes_iter),
        .abort  (bus.flush),
        .op     (op5),
        .opa    (a),
        .opb    (b),
        .done   (iter_done),
        .result (iter_result)
    );
endmodule

// File: doc/alu_multicycle.md
Name: alu_multicycle

Overview:
- Parametrised execute-stage ALU. Generalises the single-cycle integer ALU to XLEN bits and adds the RV32M/RV64M multiply/divide operations.
- Single-cycle ops keep latency 1. MUL* ops are either single-cycle or iterative, selected by parameter. DIV/REM ops are iterative radix-2.
- Sits in the EX stage behind a valid/ready handshake. The hazard unit stalls the pipeline on inReady low and kills in-flight work with flush.

Parameters:
- XLEN, 32, datapath width (32 or 64).
- FAST_MUL, 1, 1 = combinational multiplier registered once (latency 1); 0 = shift-add multiplier, XLEN iterations.
- OP_W, 5, width of the operation code.

Ports:
- clk  input  1  clock, rising edge.
- rstN  input  1  asynchronous active-low reset.
- flush  input  1  discard any accepted or in-flight op.
- inValid  input  1  operands and op are valid.
- inReady  output  1  block can accept an op this cycle.
- in1  input  XLEN  operand 1 (rs1).
- in2  input  XLEN  operand 2 (rs2/imm).
- aluOperation  input  OP_W  operation code from the package.
- outValid  output  1  result valid; held until outReady.
- outReady  input  1  consumer takes the result.
- aluOutput  output  XLEN  registered result.
- branch  output  1  registered branch-taken flag.
- busy  output  1  iterative op in progress (ITER state).

Behaviour:
- Reset (rstN low, asynchronous) forces:
  - state IDLE;
  - outValid=0, aluOutput=0, branch=0, busy=0;
  - all iteration registers cleared.
- States:
  - IDLE: no result pending.
  - ITER: iterative op running.
  - DONE: result held.
- Accept: occurs when inValid && inReady && !flush.
  - inReady = (state==IDLE) || (state==DONE && outReady).
  - This allows back-to-back single-cycle ops at one per cycle.
- Single-cycle ops (ADD..SLTU, BEQ..BGEU, and MUL* when FAST_MUL=1):
  - Result is registered on the accept edge; next state is DONE; outValid is high the following cycle (latency 1).
  - Semantics are identical to the existing single-cycle ALU at XLEN. Shift amount is in2[log2(XLEN)-1:0].
- MUL family:
  - MUL returns the low XLEN bits of the product.
  - MULH, MULHSU and MULHU return the high XLEN bits, with signed×signed, signed×unsigned and unsigned×unsigned operands respectively.
  - With FAST_MUL=0: operands are converted to magnitudes, XLEN shift-add iterations run in ITER, and the result is sign-corrected. Accept is cycle 0; outValid rises at cycle XLEN+1.
- DIV, DIVU, REM, REMU:
  - Restoring radix-2 divide on magnitudes, XLEN iterations in ITER, sign-corrected at the end.
  - Signs: quotient negative iff operand signs differ; remainder takes the dividend's sign.
  - outValid at cycle XLEN+1.
- Divide special cases (resolved at accept, latency 1, no ITER):
  - Divisor 0: quotient = all ones; remainder = in1.
  - Signed overflow (in1 = most-negative, in2 = −1): quotient = in1; remainder = 0.
- branch is written only by branch ops; every other op writes branch=0.
- Undefined opcode: aluOutput=0, branch=0, latency 1. Never X.
- DONE state:
  - outValid=1. aluOutput and branch are stable while outReady=0.
  - outReady=1 with no new accept: next state IDLE, outValid=0.
  - outReady=1 with a new accept: treated as a fresh accept.
- Flush:
  - From any state, next state is IDLE, outValid=0, busy=0. Iteration is aborted with no result.
  - flush overrides a simultaneous inValid; the op is not accepted.
  - flush overrides a simultaneous outReady; the held result counts as discarded.
- inValid while in ITER is ignored (inReady=0). Operands are captured at accept, so later changes to in1/in2 have no effect.
- Reset asserted mid-iteration behaves exactly as reset from idle.

Decomposition:
- defaultParametersPkg extended with:
  - existing ADD..BGEU codes, zero-extended to OP_W;
  - MUL=16, MULH=17, MULHSU=18, MULHU=19, DIV=20, DIVU=21, REM=22, REMU=23;
  - state enum aluStateT {IDLE, ITER, DONE}.
- One sub-module, iter_muldiv, holds the shared XLEN-iteration shift-add/restoring-divide datapath. Interface: start, op, operands, done, result.
- The top level holds the single-cycle ops, the FSM and the handshake.

Test Plan:
1. XLEN=32: ADD 5+7, then SUB 3−5 back-to-back, outReady=1 → outValid on cycles 1 and 2; results 12 and 0xFFFF_FFFE; inReady stays high.
2. BLT in1=−1, in2=1 → branch=1, aluOutput=0. BGEU with the same operands → branch=1 (0xFFFF_FFFF ≥ 1 unsigned).
3. FAST_MUL=0, MULH 0x8000_0000 × 0x8000_0000 → outValid at cycle 33, result 0x4000_0000. MULHU 0xFFFF_FFFF × 2 → 1.
4. DIV −7/2 → −3; REM −7/2 → −1; DIVU 7/0 → 0xFFFF_FFFF; REM 7/0 → 7 at latency 1; DIV 0x8000_0000/−1 → 0x8000_0000, REM → 0.
5. DIVU in ITER at cycle 10, assert flush → next cycle IDLE, outValid=0, busy=0. Same-cycle inValid+flush → nothing accepted.
6. Result in DONE, outReady=0 for 4 cycles → aluOutput and branch stable, inReady=0. Assert rstN low mid-DIV → outputs 0 immediately, without waiting for a clock edge.
